load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's data-memory request port and the word-wide ram block,
//  and is the only master driving ram's we/addr/data_i.
//  Accepts byte/half/word loads and stores over a valid/ready handshake.
//  Performs read-modify-write for sub-word stores, since ram writes only full words.
//  Extracts and sign/zero-extends load data. Returns a one-cycle response pulse.
// PARAMETERS
//  ADDR_W  32  width of req_addr (byte address)
//  RAM_AW  16  word-index bits sent to ram; ram_addr = zero-ext(req_addr[RAM_AW+1:2])
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit idle, accepts request this cycle
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32  store data, right-justified
//  rsp_valid     out  1   one-cycle response pulse
//  rsp_rdata     out  32  extended load data (0 for stores/errors)
//  rsp_err       out  1   request rejected, valid with rsp_valid
//  ram_we        out  1   ram write enable
//  ram_addr      out  32  ram word index
//  ram_wdata     out  32  ram write data
//  ram_rdata     in   32  ram read data, valid the cycle after ram_addr is presented
// BEHAVIOUR
//  - Reset (async): state IDLE; rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata = 0.
//    req_ready = (state==IDLE) && !reset.
//  - Accept on a clk edge with req_valid && req_ready. All req_* fields are latched at accept.
//    req_* fields are ignored when the request is not accepted.
//  - FSM states: IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP.
//    load:            IDLE->RD_ISSUE->RD_WAIT->RESP->IDLE; rsp_valid 3 cycles after accept
//    sub-word store:  IDLE->RD_ISSUE->RD_WAIT->WRITE->RESP->IDLE; rsp_valid 4 cycles after accept
//    word store:      IDLE->WRITE->RESP->IDLE; rsp_valid 2 cycles after accept
//    error:           IDLE->RESP->IDLE; rsp_valid 1 cycle after accept; no ram access
//  - RD_ISSUE: ram_addr = word index, ram_we=0. RD_WAIT: ram_rdata is captured at the end of the cycle.
//  - WRITE: ram_we=1 for exactly one cycle, with ram_addr and merged ram_wdata.
//    ram_we is 0 in every other state.
//  - Lanes are little-endian: lane k = bits[8k+7:8k], lane = addr[1:0].
//    Byte store replaces lane addr[1:0]; half store replaces lanes {addr[1],0} and {addr[1],1}.
//    Unselected lanes keep the captured ram_rdata.
//  - Load extract: right-shift the captured word by 8*lane, mask to size, extend per req_unsigned.
//    Word loads are passed through unchanged.
//  - RESP: rsp_valid=1 for one cycle; no response back-pressure. req_ready is 0 in RESP.
//    A new request can be accepted at the earliest in the cycle after RESP.
//  - rsp_rdata and rsp_err hold their values until the next response; rsp_rdata=0 for stores and errors.
//  - req_size=11 always gives rsp_err=1 (error path).
//  - Reset mid-operation aborts the operation. A store whose WRITE state has not yet been reached
//    never asserts ram_we. No response is generated for an aborted request.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    half with addr[0]!=0, or word with addr[1:0]!=0 -> error path, rsp_err=1.
//  LSU_MISALIGN_TRAP_EN undefined:
//    low address bits are forced to alignment (half clears addr[0], word clears addr[1:0]);
//    the access proceeds normally; rsp_err is set only for req_size=11.
// TESTING
//  1 word store 0x100 <- 0xDEADBEEF -> one ram_we cycle, ram_addr=0x40, ram_wdata=0xDEADBEEF,
//    rsp_valid 2 cycles after accept; then word load 0x100 -> rsp_rdata=0xDEADBEEF 3 cycles after accept.
//  2 byte store 0x80 to 0x101 -> read of 0x40, then write 0xDEAD80EF;
//    signed byte load 0x101 -> 0xFFFFFF80; unsigned -> 0x00000080.
//  3 signed half load 0x102 -> 0xFFFFDEAD; unsigned half load 0x100 -> 0x000080EF.
//  4 word load 0x102: with macro -> rsp_err=1 one cycle after accept, ram_we never asserted;
//    without macro -> rsp_rdata=0xDEAD80EF, rsp_err=0.
//  5 reset asserted during RD_WAIT of a byte store -> ram_we never asserts, no rsp_valid,
//    req_ready=1 the cycle after release, word 0x40 unchanged.
//  6 req_valid held high for back-to-back loads -> second accept only in the cycle after RESP;
//    req_size=11 -> rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the core data port and a word-wide ram; sub-word stores use read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses take the error path).
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_we,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the response is a single rsp_valid pulse
    // in RESP that the requester cannot stall.

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic        accept;
    logic        req_err;
    logic [1:0]  req_lane;
    logic [31:0] req_index;
    logic        unused_addr_bits;

    logic        op_we;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [1:0]  op_lane;
    logic [31:0] op_wdata;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    assign unused_addr_bits = ^req_addr[ADDR_W-1:RAM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misaligned;
    assign req_misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                            ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_err = (req_size == SZ_RSVD) || req_misaligned;
`else
    assign req_err = (req_size == SZ_RSVD);
`endif

    // Lane is forced to the natural alignment of the access size; with the trap
    // enabled a misaligned request never gets this far, so the forcing is harmless.
    always_comb begin
        req_lane = req_addr[1:0];
        case (req_size)
            SZ_HALF: req_lane = {req_addr[1], 1'b0};
            SZ_WORD: req_lane = 2'b00;
            default: req_lane = req_addr[1:0];
        endcase
    end

    always_comb begin
        req_index = '0;
        req_index[RAM_AW-1:0] = req_addr[RAM_AW+1:2];
    end

    function automatic logic [31:0] merge_word(input logic [31:0] base,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = base;
        case (size)
            SZ_BYTE: w[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract_word(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned,
                                                 input logic [1:0]  lane);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            SZ_HALF: r = is_unsigned ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT:  next_state = op_we ? WRITE : RESP;
            WRITE:    next_state = RESP;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_we       <= 1'b0;
            op_size     <= 2'b00;
            op_unsigned <= 1'b0;
            op_lane     <= 2'b00;
            op_wdata    <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            // Registered so ram_we is high for exactly the single WRITE cycle.
            ram_we <= (next_state == WRITE);

            if (accept) begin
                op_we       <= req_we;
                op_size     <= req_size;
                op_unsigned <= req_unsigned;
                op_lane     <= req_lane;
                op_wdata    <= req_wdata;
                if (!req_err) begin
                    ram_addr <= req_index;
                end
                if (req_we && (req_size == SZ_WORD) && !req_err) begin
                    ram_wdata <= req_wdata;
                end
            end

            // ram_rdata is valid during RD_WAIT; merge it into the write word here.
            if ((state == RD_WAIT) && op_we) begin
                ram_wdata <= merge_word(ram_rdata, op_wdata, op_size, op_lane);
            end

            if ((next_state == RESP) && (state != RESP)) begin
                rsp_err <= (state == IDLE);
                if ((state == RD_WAIT) && !op_we) begin
                    rsp_rdata <= extract_word(ram_rdata, op_size, op_unsigned, op_lane);
                end else begin
                    rsp_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural one-cycle-latency word ram.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ADDR_W(32), .RAM_AW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ram model: read data appears the cycle after the address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: issue one request, then follow it until the response pulse
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] lat, output logic [31:0] rdata,
                          output logic [31:0] err, output logic [31:0] we_cnt,
                          output logic [31:0] waddr, output logic [31:0] wdat);
        int w;
        lat = 32'hFFFF_FFFF; rdata = 'x; err = 'x; we_cnt = 0; waddr = 'x; wdat = 'x;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        // scramble the request fields to show they were latched at accept
        req_valid = 1'b0;
        req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 10; k++) begin
            if (ram_we) begin
                we_cnt = we_cnt + 1;
                waddr = ram_addr;
                wdat = ram_wdata;
            end
            if (rsp_valid) begin
                lat = k;
                rdata = rsp_rdata;
                err = {31'h0, rsp_err};
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [31:0] lat, rdata, err, we_cnt, waddr, wdat;
    int a0, a1, rsp_cnt, ready_in_resp, we_seen, rsp_seen;
    logic [31:0] last_rdata;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_ram_we", {31'h0, ram_we}, 32'h0);
        check("reset_ram_addr", ram_addr, 32'h0);
        check("reset_ram_wdata", ram_wdata, 32'h0);
        check("reset_rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // 1: word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rdata, err, we_cnt, waddr, wdat);
        check("sw_lat", lat, 32'd2);
        check("sw_we_cnt", we_cnt, 32'd1);
        check("sw_ram_addr", waddr, 32'h40);
        check("sw_ram_wdata", wdat, 32'hDEADBEEF);
        check("sw_rdata", rdata, 32'h0);
        check("sw_err", err, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lw_lat", lat, 32'd3);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        check("lw_we_cnt", we_cnt, 32'd0);

        // 2: byte store with read-modify-write, then byte loads
        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h80, lat, rdata, err, we_cnt, waddr, wdat);
        check("sb_lat", lat, 32'd4);
        check("sb_we_cnt", we_cnt, 32'd1);
        check("sb_ram_addr", waddr, 32'h40);
        check("sb_ram_wdata", wdat, 32'hDEAD80EF);
        check("sb_mem", mem[8'h40], 32'hDEAD80EF);
        do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lb_lat", lat, 32'd3);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lbu_rdata", rdata, 32'h00000080);

        // 3: half loads
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lh_rdata", rdata, 32'hFFFFDEAD);
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lhu_rdata", rdata, 32'h000080EF);

        // 4: misaligned word load
        do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat", lat, 32'd1);
        check("mis_err", err, 32'h1);
        check("mis_rdata", rdata, 32'h0);
        check("mis_we_cnt", we_cnt, 32'd0);
`else
        check("mis_lat", lat, 32'd3);
        check("mis_err", err, 32'h0);
        check("mis_rdata", rdata, 32'hDEAD80EF);
`endif

        // 5: reset during RD_WAIT of a byte store
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ram_we", {31'h0, ram_we}, 32'h0);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("abort_ready_in_reset", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready_after", {31'h0, req_ready}, 32'h1);
        we_seen = 0; rsp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_we) we_seen++;
            if (rsp_valid) rsp_seen++;
        end
        check("abort_no_we", we_seen, 32'd0);
        check("abort_no_rsp", rsp_seen, 32'd0);
        check("abort_mem", mem[8'h40], 32'hDEAD80EF);

        // 6: back-to-back loads with req_valid held high
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0; req_valid = 1'b1;
        a0 = -1; a1 = -1; rsp_cnt = 0; ready_in_resp = 0; last_rdata = 'x;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                if (a0 < 0) a0 = c;
                else if (a1 < 0) a1 = c;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rdata = rsp_rdata;
                if (req_ready) ready_in_resp++;
            end
            @(negedge clk);
        end
        check("b2b_first_accept", a0, 32'd0);
        check("b2b_second_accept", a1, 32'd4);
        check("b2b_rsp_cnt", rsp_cnt, 32'd2);
        check("b2b_ready_in_resp", ready_in_resp, 32'd0);
        check("b2b_rdata", last_rdata, 32'hDEAD80EF);

        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("rsvd_lat", lat, 32'd1);
        check("rsvd_err", err, 32'h1);
        check("rsvd_rdata", rdata, 32'h0);
        check("rsvd_we_cnt", we_cnt, 32'd0);

        // half store into the upper lanes, then sub-word loads of the result
        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'hABCD1234, lat, rdata, err, we_cnt, waddr, wdat);
        check("sh_lat", lat, 32'd4);
        check("sh_we_cnt", we_cnt, 32'd1);
        check("sh_ram_wdata", wdat, 32'h123480EF);
        check("sh_err", err, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lbu_hi_rdata", rdata, 32'h00000012);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rdata, err, we_cnt, waddr, wdat);
        check("lh_hi_rdata", rdata, 32'h00001234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
